chroni_line_scheduler: RTL and testbench

CHRONI_LINE_SCHEDULER -- requirements
Module: chroni_line_scheduler

---
 rtl/chroni_line_scheduler.sv | 209 ++++++++++++++++++++
 tb/tb_chroni_line_scheduler.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/chroni_line_scheduler.sv
// chroni_line_scheduler: fetches source lines from VRAM into a two-half line
// buffer, one line ahead of the VGA scanout, refilling a half each time the
// display side finishes repeating a source line.
module chroni_line_scheduler #(
  parameter int LINE_WIDTH = 640,
  parameter int LINE_COUNT = 480,
  parameter int ADDR_W     = 19
) (
  input  logic              sys_clk,
  input  logic              reset,
  input  logic              frame_start,
  input  logic              render_start,
  input  logic              scanline_start,
  input  logic              mode_changed,
  input  logic              pixel_scale,
  output logic              vram_req,
  output logic [ADDR_W-1:0] vram_addr,
  input  logic              vram_ack,
  input  logic [7:0]        vram_data,
  output logic              lb_we,
  output logic [10:0]       lb_addr,
  output logic [7:0]        lb_data,
  output logic              busy,
  output logic              overrun,
  output logic              display_buffer
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ARMED = 3'd1;
  localparam logic [2:0] S_FILL  = 3'd2;
  localparam logic [2:0] S_WAIT  = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam int              LF_W       = $clog2(LINE_COUNT + 1);
  localparam logic [LF_W-1:0] LF_FULL    = LF_W'(LINE_COUNT);
  localparam logic [1:0]      PEND_INIT  = (LINE_COUNT >= 2) ? 2'd2 : 2'(LINE_COUNT);
  localparam logic [10:0]     HALF1_BASE = 11'(LINE_WIDTH);
  localparam logic [10:0]     X_LAST     = 11'(LINE_WIDTH - 1);
  localparam logic [ADDR_W-1:0] LINE_STEP = ADDR_W'(LINE_WIDTH);

  logic [2:0]        state_q, state_d;
  logic [ADDR_W-1:0] line_base_q, line_base_d;
  logic [LF_W-1:0]   lines_fetched_q, lines_fetched_d;
  logic [1:0]        pending_q, pending_d;
  logic [1:0]        scan_q, scan_d;
  logic              rep4_q, rep4_d;
  logic              fill_half_q, fill_half_d;
  logic              disp_q, disp_d;
  logic              overrun_q, overrun_d;
  logic [10:0]       x_q, x_d;
  logic              req_q, req_d;
  logic              we_q, we_d;
  logic [10:0]       lb_addr_q, lb_addr_d;
  logic [7:0]        lb_data_q, lb_data_d;

  logic abort;
  logic accept;
  logic counting;
  logic trig;
  logic pend_inc;
  logic fill_done;

  assign abort    = mode_changed | frame_start;
  assign accept   = req_q & vram_ack & ~abort;
  assign counting = (state_q == S_FILL) || (state_q == S_WAIT) || (state_q == S_DONE);

  assign vram_req       = req_q;
  assign vram_addr      = line_base_q + ADDR_W'(x_q);
  assign lb_we          = we_q;
  assign lb_addr        = lb_addr_q;
  assign lb_data        = lb_data_q;
  assign busy           = (state_q == S_FILL);
  assign overrun        = overrun_q;
  assign display_buffer = disp_q;

  // Next-state logic: abort events first, then render arm, scanline triggers and fill progress.
  always_comb begin
    state_d         = state_q;
    line_base_d     = line_base_q;
    lines_fetched_d = lines_fetched_q;
    pending_d       = pending_q;
    scan_d          = scan_q;
    rep4_d          = rep4_q;
    fill_half_d     = fill_half_q;
    disp_d          = disp_q;
    overrun_d       = overrun_q;
    x_d             = x_q;
    req_d           = req_q;
    we_d            = 1'b0;
    lb_addr_d       = lb_addr_q;
    lb_data_d       = lb_data_q;
    trig            = 1'b0;
    pend_inc        = 1'b0;
    fill_done       = 1'b0;

    if (mode_changed) begin
      state_d   = S_IDLE;
      pending_d = 2'd0;
      req_d     = 1'b0;
      x_d       = 11'd0;
    end else if (frame_start) begin
      state_d         = S_ARMED;
      line_base_d     = '0;
      lines_fetched_d = '0;
      pending_d       = 2'd0;
      scan_d          = 2'd0;
      fill_half_d     = 1'b0;
      disp_d          = 1'b0;
      overrun_d       = 1'b0;
      req_d           = 1'b0;
      x_d             = 11'd0;
    end else if (render_start && (state_q == S_ARMED)) begin
      rep4_d    = pixel_scale;
      pending_d = PEND_INIT;
      state_d   = S_FILL;
    end else begin
      // A wrap of the repeat counter means the VGA side has moved to the other half.
      if (scanline_start && counting) begin
        if (scan_q == (rep4_q ? 2'd3 : 2'd1)) begin
          scan_d = 2'd0;
          disp_d = ~disp_q;
          trig   = 1'b1;
        end else begin
          scan_d = scan_q + 2'd1;
        end
      end

      // Triggers beyond the frame's last line are ignored; a third queued fill is lost.
      if (trig) begin
        if (int'(lines_fetched_q) + int'(pending_q) >= LINE_COUNT) begin
          pend_inc = 1'b0;
        end else if (pending_q == 2'd2) begin
          overrun_d = 1'b1;
        end else begin
          pend_inc = 1'b1;
        end
      end

      if (accept) begin
        we_d      = 1'b1;
        lb_addr_d = (fill_half_q ? HALF1_BASE : 11'd0) + x_q;
        lb_data_d = vram_data;
        if (x_q == X_LAST) begin
          fill_done = 1'b1;
        end else begin
          x_d = x_q + 11'd1;
        end
      end

      pending_d = pending_q + {1'b0, pend_inc} - {1'b0, fill_done};

      // A completed line always drops the request for one cycle before the next fill.
      if (fill_done) begin
        req_d           = 1'b0;
        x_d             = 11'd0;
        line_base_d     = line_base_q + LINE_STEP;
        lines_fetched_d = lines_fetched_q + LF_W'(1);
        fill_half_d     = ~fill_half_q;
        if (pending_d != 2'd0) begin
          state_d = S_FILL;
        end else if (lines_fetched_d == LF_FULL) begin
          state_d = S_DONE;
        end else begin
          state_d = S_WAIT;
        end
      end else if ((state_q == S_FILL) && !req_q) begin
        req_d = 1'b1;
      end else if ((state_q == S_WAIT) && (pending_q != 2'd0)) begin
        state_d = S_FILL;
      end
    end
  end

  // State and output registers; everything clears under reset.
  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      state_q         <= S_IDLE;
      line_base_q     <= '0;
      lines_fetched_q <= '0;
      pending_q       <= 2'd0;
      scan_q          <= 2'd0;
      rep4_q          <= 1'b0;
      fill_half_q     <= 1'b0;
      disp_q          <= 1'b0;
      overrun_q       <= 1'b0;
      x_q             <= 11'd0;
      req_q           <= 1'b0;
      we_q            <= 1'b0;
      lb_addr_q       <= 11'd0;
      lb_data_q       <= 8'd0;
    end else begin
      state_q         <= state_d;
      line_base_q     <= line_base_d;
      lines_fetched_q <= lines_fetched_d;
      pending_q       <= pending_d;
      scan_q          <= scan_d;
      rep4_q          <= rep4_d;
      fill_half_q     <= fill_half_d;
      disp_q          <= disp_d;
      overrun_q       <= overrun_d;
      x_q             <= x_d;
      req_q           <= req_d;
      we_q            <= we_d;
      lb_addr_q       <= lb_addr_d;
      lb_data_q       <= lb_data_d;
    end
  end

endmodule

// File: tb/tb_chroni_line_scheduler.sv
// Testbench for chroni_line_scheduler: instance A (LINE_COUNT=3) and
// instance B (LINE_COUNT=8), LINE_WIDTH=4, VRAM data mirrors the address.
module tb_chroni_line_scheduler;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_WAIT = 3'd3;
  localparam logic [2:0] ST_DONE = 3'd4;

  logic        sys_clk = 1'b0;
  logic        reset = 1'b1;
  logic        frame_start = 1'b0;
  logic        render_start = 1'b0;
  logic        scanline_start = 1'b0;
  logic        mode_changed = 1'b0;
  logic        pixel_scale = 1'b0;
  logic        vram_ack = 1'b0;

  logic        vram_req_a, lb_we_a, busy_a, overrun_a, disp_a;
  logic [18:0] vram_addr_a;
  logic [7:0]  vram_data_a, lb_data_a;
  logic [10:0] lb_addr_a;

  logic        vram_req_b, lb_we_b, busy_b, overrun_b, disp_b;
  logic [18:0] vram_addr_b;
  logic [7:0]  vram_data_b, lb_data_b;
  logic [10:0] lb_addr_b;

  assign vram_data_a = vram_addr_a[7:0];
  assign vram_data_b = vram_addr_b[7:0];

  int n_cmp = 0;
  int n_fail = 0;

  logic [18:0] exp_q[$];
  logic [18:0] obs_q[$];

  always #5 sys_clk = ~sys_clk;

  chroni_line_scheduler #(.LINE_WIDTH(4), .LINE_COUNT(3), .ADDR_W(19)) dut_a (
    .sys_clk(sys_clk), .reset(reset), .frame_start(frame_start), .render_start(render_start),
    .scanline_start(scanline_start), .mode_changed(mode_changed), .pixel_scale(pixel_scale),
    .vram_req(vram_req_a), .vram_addr(vram_addr_a), .vram_ack(vram_ack), .vram_data(vram_data_a),
    .lb_we(lb_we_a), .lb_addr(lb_addr_a), .lb_data(lb_data_a), .busy(busy_a),
    .overrun(overrun_a), .display_buffer(disp_a)
  );

  chroni_line_scheduler #(.LINE_WIDTH(4), .LINE_COUNT(8), .ADDR_W(19)) dut_b (
    .sys_clk(sys_clk), .reset(reset), .frame_start(frame_start), .render_start(render_start),
    .scanline_start(scanline_start), .mode_changed(mode_changed), .pixel_scale(pixel_scale),
    .vram_req(vram_req_b), .vram_addr(vram_addr_b), .vram_ack(vram_ack), .vram_data(vram_data_b),
    .lb_we(lb_we_b), .lb_addr(lb_addr_b), .lb_data(lb_data_b), .busy(busy_b),
    .overrun(overrun_b), .display_buffer(disp_b)
  );

  // Record every line-buffer write of instance A for the scoreboard.
  always @(negedge sys_clk) begin
    if (!reset && lb_we_a) obs_q.push_back({lb_addr_a, lb_data_a});
  end

  task automatic pulse_frame();
    @(posedge sys_clk); #1 frame_start = 1'b1;
    @(posedge sys_clk); #1 frame_start = 1'b0;
  endtask

  task automatic pulse_render();
    @(posedge sys_clk); #1 render_start = 1'b1;
    @(posedge sys_clk); #1 render_start = 1'b0;
  endtask

  task automatic pulse_scan();
    @(posedge sys_clk); #1 scanline_start = 1'b1;
    @(posedge sys_clk); #1 scanline_start = 1'b0;
  endtask

  task automatic push_line(input int lb_base, input int data_base);
    for (int i = 0; i < 4; i++) exp_q.push_back({11'(lb_base + i), 8'(data_base + i)});
  endtask

  task automatic test_reset();
    repeat (2) @(negedge sys_clk);
    n_cmp++;
    if ({vram_req_a, vram_addr_a, lb_we_a, lb_addr_a, lb_data_a, busy_a, overrun_a, disp_a} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs_a: got req=%b addr=%0d we=%b lba=%0d lbd=%0d busy=%b ovr=%b disp=%b, want all 0",
               vram_req_a, vram_addr_a, lb_we_a, lb_addr_a, lb_data_a, busy_a, overrun_a, disp_a);
    end
    n_cmp++;
    if ({vram_req_b, vram_addr_b, lb_we_b, lb_addr_b, lb_data_b, busy_b, overrun_b, disp_b} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs_b: outputs not all 0 under reset");
    end
    n_cmp++;
    if (dut_a.state_q !== ST_IDLE) begin
      n_fail++;
      $display("FAIL reset_state: got %0d, want %0d", dut_a.state_q, ST_IDLE);
    end
    @(posedge sys_clk); #1 reset = 1'b0;
  endtask

  task automatic test_no_frame();
    pulse_render();
    for (int i = 0; i < 6; i++) begin
      @(negedge sys_clk);
      n_cmp++;
      if (vram_req_a !== 1'b0) begin
        n_fail++;
        $display("FAIL no_frame_req cycle %0d: got %b, want 0", i, vram_req_a);
      end
    end
    n_cmp++;
    if (dut_a.state_q !== ST_IDLE) begin
      n_fail++;
      $display("FAIL no_frame_state: got %0d, want %0d", dut_a.state_q, ST_IDLE);
    end
  endtask

  task automatic test_fill_two(input logic scale);
    logic [18:0] e, o;
    int t;
    pixel_scale = scale;
    vram_ack = 1'b1;
    pulse_frame();
    push_line(0, 0);
    push_line(4, 4);
    pulse_render();
    pixel_scale = ~scale;
    t = 0;
    while (obs_q.size() < exp_q.size() && t < 100) begin @(posedge sys_clk); t++; end
    repeat (8) @(posedge sys_clk);
    #1;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_cmp++;
      if (obs_q.size() == 0) begin
        n_fail++;
        $display("FAIL fill_two write missing: want addr %0d data %0d", e[18:8], e[7:0]);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          n_fail++;
          $display("FAIL fill_two write: got addr %0d data %0d, want addr %0d data %0d", o[18:8], o[7:0], e[18:8], e[7:0]);
        end
      end
    end
    n_cmp++;
    if (obs_q.size() != 0) begin
      n_fail++;
      $display("FAIL fill_two extra writes: got %0d, want 0", obs_q.size());
    end
    obs_q.delete();
    n_cmp++;
    if (busy_a !== 1'b0 || dut_a.state_q !== ST_WAIT) begin
      n_fail++;
      $display("FAIL fill_two end: got busy=%b state=%0d, want busy=0 state=%0d", busy_a, dut_a.state_q, ST_WAIT);
    end
  endtask

  task automatic test_refill_done();
    logic [18:0] e, o;
    int t;
    pulse_scan();
    push_line(0, 8);
    pulse_scan();
    n_cmp++;
    if (disp_a !== 1'b1) begin
      n_fail++;
      $display("FAIL refill_display: got %b, want 1", disp_a);
    end
    t = 0;
    while (obs_q.size() < exp_q.size() && t < 100) begin @(posedge sys_clk); t++; end
    repeat (8) @(posedge sys_clk);
    #1;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_cmp++;
      if (obs_q.size() == 0) begin
        n_fail++;
        $display("FAIL refill write missing: want addr %0d data %0d", e[18:8], e[7:0]);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          n_fail++;
          $display("FAIL refill write: got addr %0d data %0d, want addr %0d data %0d", o[18:8], o[7:0], e[18:8], e[7:0]);
        end
      end
    end
    n_cmp++;
    if (dut_a.state_q !== ST_DONE) begin
      n_fail++;
      $display("FAIL refill_state: got %0d, want %0d", dut_a.state_q, ST_DONE);
    end
    pulse_scan();
    pulse_scan();
    repeat (8) @(posedge sys_clk);
    #1;
    n_cmp++;
    if (obs_q.size() != 0) begin
      n_fail++;
      $display("FAIL done_no_writes: got %0d writes, want 0", obs_q.size());
    end
    obs_q.delete();
    n_cmp++;
    if (overrun_a !== 1'b0) begin
      n_fail++;
      $display("FAIL done_overrun: got %b, want 0", overrun_a);
    end
  endtask

  task automatic test_scale4();
    logic [18:0] e, o;
    int t;
    test_fill_two(1'b1);
    for (int i = 0; i < 3; i++) pulse_scan();
    repeat (8) @(posedge sys_clk);
    #1;
    n_cmp++;
    if (obs_q.size() != 0 || dut_a.state_q !== ST_WAIT) begin
      n_fail++;
      $display("FAIL scale4_early: got %0d writes state=%0d, want 0 writes state=%0d", obs_q.size(), dut_a.state_q, ST_WAIT);
    end
    obs_q.delete();
    push_line(0, 8);
    pulse_scan();
    t = 0;
    while (obs_q.size() < exp_q.size() && t < 100) begin @(posedge sys_clk); t++; end
    repeat (8) @(posedge sys_clk);
    #1;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_cmp++;
      if (obs_q.size() == 0) begin
        n_fail++;
        $display("FAIL scale4 write missing: want addr %0d data %0d", e[18:8], e[7:0]);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          n_fail++;
          $display("FAIL scale4 write: got addr %0d data %0d, want addr %0d data %0d", o[18:8], o[7:0], e[18:8], e[7:0]);
        end
      end
    end
    n_cmp++;
    if (disp_a !== 1'b1) begin
      n_fail++;
      $display("FAIL scale4_display: got %b, want 1", disp_a);
    end
    obs_q.delete();
  endtask

  task automatic test_overrun();
    int t;
    vram_ack = 1'b0;
    pixel_scale = 1'b1;
    pulse_frame();
    pulse_render();
    t = 0;
    while (!vram_req_b && t < 20) begin @(posedge sys_clk); #1; t++; end
    n_cmp++;
    if (vram_req_b !== 1'b1) begin
      n_fail++;
      $display("FAIL overrun_req: got %b, want 1 (timeout)", vram_req_b);
    end
    pulse_scan();
    pulse_scan();
    n_cmp++;
    if (overrun_b !== 1'b0 || busy_b !== 1'b1) begin
      n_fail++;
      $display("FAIL overrun_two_pulses: got ovr=%b busy=%b, want ovr=0 busy=1", overrun_b, busy_b);
    end
    pulse_scan();
    pulse_scan();
    n_cmp++;
    if (overrun_b !== 1'b1) begin
      n_fail++;
      $display("FAIL overrun_set: got %b, want 1", overrun_b);
    end
    pulse_frame();
    n_cmp++;
    if (overrun_b !== 1'b0) begin
      n_fail++;
      $display("FAIL overrun_clear: got %b, want 0", overrun_b);
    end
    obs_q.delete();
  endtask

  task automatic test_mode_abort();
    int t;
    vram_ack = 1'b0;
    pixel_scale = 1'b0;
    pulse_frame();
    pulse_render();
    t = 0;
    while (!vram_req_a && t < 20) begin @(posedge sys_clk); #1; t++; end
    n_cmp++;
    if (vram_req_a !== 1'b1) begin
      n_fail++;
      $display("FAIL abort_req_wait: got %b, want 1 (timeout)", vram_req_a);
    end
    vram_ack = 1'b1;
    mode_changed = 1'b1;
    @(posedge sys_clk); #1;
    mode_changed = 1'b0;
    vram_ack = 1'b0;
    n_cmp++;
    if (lb_we_a !== 1'b0 || vram_req_a !== 1'b0 || busy_a !== 1'b0 || dut_a.state_q !== ST_IDLE) begin
      n_fail++;
      $display("FAIL abort_result: got we=%b req=%b busy=%b state=%0d, want 0 0 0 %0d",
               lb_we_a, vram_req_a, busy_a, dut_a.state_q, ST_IDLE);
    end
    repeat (4) @(posedge sys_clk);
    #1;
    n_cmp++;
    if (obs_q.size() != 0) begin
      n_fail++;
      $display("FAIL abort_no_writes: got %0d writes, want 0", obs_q.size());
    end
    obs_q.delete();
  endtask

  initial begin
    test_reset();
    test_no_frame();
    test_fill_two(1'b0);
    test_refill_done();
    test_scale4();
    test_overrun();
    test_mode_abort();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
